// File: rtl/config_chain_controller_if.sv
// Bundles the bitstream memory, configuration chain and host handshake signals.
// Latency: none (wires only).
// Backpressure: none; the controller ignores start while busy.
interface config_chain_controller_if #(
  parameter int ADDR_WIDTH = 14
);

  // Host request and status
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  error;

  // Bitstream memory read port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  bit_in;

  // Configuration chain serial port
  logic                  chain_head;
  logic                  prog_clk;
  logic                  chain_tail;

  // Controller side: drives the memory address and the chain
  modport master (
    input  start,
    input  abort,
    input  bit_in,
    input  chain_tail,
    output mem_addr,
    output chain_head,
    output prog_clk,
    output busy,
    output done,
    output error
  );

  // Environment side: host, memory and chain
  modport slave (
    output start,
    output abort,
    output bit_in,
    output chain_tail,
    input  mem_addr,
    input  chain_head,
    input  prog_clk,
    input  busy,
    input  done,
    input  error
  );

endinterface

// File: rtl/config_chain_controller.sv
// Configuration chain loader: shifts a memory-held bitstream into a serial chain, optional readback verify pass.
// Latency: 1 + 2*CLK_DIV clk per bit; a load is BITSTREAM_SIZE bits, twice that when VERIFY=1.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next edge.
module config_chain_controller #(
  parameter int BITSTREAM_SIZE = 6140,
  parameter int ADDR_WIDTH     = 14,
  parameter int CLK_DIV        = 2,
  parameter int VERIFY         = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  config_chain_controller_if.master bus
);

  localparam int CNT_W = (BITSTREAM_SIZE > 1) ? $clog2(BITSTREAM_SIZE) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITSTREAM_SIZE - 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]            div_cnt_q, div_cnt_d;
  logic                  pass_q, pass_d;
  logic                  chain_head_q, chain_head_d;
  logic                  prog_clk_q, prog_clk_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  active;
  logic                  div_end;

  assign active  = (state_q == FETCH) || (state_q == LOW) || (state_q == HIGH);
  assign div_end = (div_cnt_q == DIV_LAST);

  // Next-state, datapath updates and registered-output decode
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    pass_d       = pass_q;
    chain_head_d = chain_head_q;
    error_d      = error_q;

    if (bus.abort && active) begin
      // Abort beats everything; data registers and the error flag keep their values
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d    = FETCH;
            mem_addr_d = '0;
            bit_cnt_d  = '0;
            pass_d     = 1'b0;
            error_d    = 1'b0;
          end
        end

        FETCH: begin
          // Memory data for mem_addr is valid by now; present it to the chain
          state_d      = LOW;
          chain_head_d = bus.bit_in;
          div_cnt_d    = '0;
        end

        LOW: begin
          if (div_end) begin
            state_d   = HIGH;
            div_cnt_d = '0;
            // On the verify pass the chain tail carries the bit loaded on the first pass
            if (pass_q && (bus.chain_tail != chain_head_q)) begin
              error_d = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end

        HIGH: begin
          if (div_end) begin
            div_cnt_d = '0;
            if (bit_cnt_q != LAST_BIT) begin
              state_d    = FETCH;
              bit_cnt_d  = bit_cnt_q + CNT_W'(1);
              mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
            end else if ((VERIFY != 0) && !pass_q) begin
              state_d    = FETCH;
              pass_d     = 1'b1;
              bit_cnt_d  = '0;
              mem_addr_d = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered straight from the next state so prog_clk never glitches
    prog_clk_d = (state_d == HIGH);
    busy_d     = (state_d == FETCH) || (state_d == LOW) || (state_d == HIGH);
    done_d     = (state_d == DONE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      pass_q       <= 1'b0;
      chain_head_q <= 1'b0;
      prog_clk_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      pass_q       <= pass_d;
      chain_head_q <= chain_head_d;
      prog_clk_q   <= prog_clk_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.chain_head = chain_head_q;
  assign bus.prog_clk   = prog_clk_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_config_chain_controller.sv
// Bench for config_chain_controller: three instances (plain load, verify, divided clock) against a bit-sequence model.
// Latency: expected load time is passes * bits * (1 + 2*CLK_DIV) clk.
// Backpressure: none; start held high while busy must not disturb a load.
module tb_config_chain_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  config_chain_controller_if #(.ADDR_WIDTH(8)) a_if ();
  config_chain_controller_if #(.ADDR_WIDTH(8)) b_if ();
  config_chain_controller_if #(.ADDR_WIDTH(8)) c_if ();

  config_chain_controller #(.BITSTREAM_SIZE(4), .ADDR_WIDTH(8), .CLK_DIV(1), .VERIFY(0))
    u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
  config_chain_controller #(.BITSTREAM_SIZE(4), .ADDR_WIDTH(8), .CLK_DIV(1), .VERIFY(1))
    u_dut_b (.clk(clk), .rst(rst), .bus(b_if));
  config_chain_controller #(.BITSTREAM_SIZE(5), .ADDR_WIDTH(8), .CLK_DIV(3), .VERIFY(1))
    u_dut_c (.clk(clk), .rst(rst), .bus(c_if));

  // Stimulus and observation arrays indexed by instance (0=a, 1=b, 2=c)
  logic [2:0] start_v = '0;
  logic [2:0] abort_v = '0;
  logic [2:0] flip_v  = '0;
  logic       tail_zero_b = 1'b0;
  logic [2:0] pclk_w, head_w, busy_w, done_w, err_w;
  logic [7:0] addr_w [3];

  logic mem_a [8];
  logic mem_b [8];
  logic mem_c [8];
  logic [3:0] sr_b = '0;
  logic [4:0] sr_c = '0;

  assign a_if.start = start_v[0];  assign a_if.abort = abort_v[0];
  assign b_if.start = start_v[1];  assign b_if.abort = abort_v[1];
  assign c_if.start = start_v[2];  assign c_if.abort = abort_v[2];

  assign a_if.bit_in = (a_if.mem_addr < 8'd4) ? mem_a[a_if.mem_addr[2:0]] : 1'b0;
  assign b_if.bit_in = (b_if.mem_addr < 8'd4) ? mem_b[b_if.mem_addr[2:0]] : 1'b0;
  assign c_if.bit_in = (c_if.mem_addr < 8'd5) ? mem_c[c_if.mem_addr[2:0]] : 1'b0;

  // Chain models: plain shift registers clocked by prog_clk
  always @(posedge b_if.prog_clk) sr_b <= {sr_b[2:0], b_if.chain_head};
  always @(posedge c_if.prog_clk) sr_c <= {sr_c[3:0], c_if.chain_head};
  assign a_if.chain_tail = 1'b0;
  assign b_if.chain_tail = tail_zero_b ? 1'b0 : sr_b[3];
  assign c_if.chain_tail = sr_c[4] ^ flip_v[2];

  assign pclk_w = {c_if.prog_clk,   b_if.prog_clk,   a_if.prog_clk};
  assign head_w = {c_if.chain_head, b_if.chain_head, a_if.chain_head};
  assign busy_w = {c_if.busy,       b_if.busy,       a_if.busy};
  assign done_w = {c_if.done,       b_if.done,       a_if.done};
  assign err_w  = {c_if.error,      b_if.error,      a_if.error};
  assign addr_w[0] = a_if.mem_addr;
  assign addr_w[1] = b_if.mem_addr;
  assign addr_w[2] = c_if.mem_addr;

  int n_pass  = 0;
  int n_total = 0;

  // Results of the most recent run_load
  bit         heads[$];
  bit         exp_q[$];
  int         done_k, busy_cnt, hi_bad, lo_bad, hi_runs;
  logic [7:0] addr0;
  logic       err0;

  // Pulses (or holds) start, then samples every negedge: k=0 is the first clk in FETCH
  task automatic run_load(input int d, input int div, input int budget,
                          input int abort_at, input int flip_at, input bit hold_start);
    logic prev;
    int   run_len;
    heads.delete();
    done_k = -1; busy_cnt = 0; hi_bad = 0; lo_bad = 0; hi_runs = 0;
    @(negedge clk); start_v[d] = 1'b1;
    @(negedge clk);
    if (!hold_start) start_v[d] = 1'b0;
    addr0 = addr_w[d]; err0 = err_w[d];
    prev = pclk_w[d]; run_len = 0;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) @(negedge clk);
      abort_v[d] = 1'b0;
      if (pclk_w[d] !== prev) begin
        if (prev) begin
          hi_runs++;
          if (run_len != div) hi_bad++;
        end else if (run_len != div + 1) begin
          lo_bad++;
        end
        if (pclk_w[d]) heads.push_back(head_w[d]);
        run_len = 0;
      end
      prev = pclk_w[d];
      run_len++;
      flip_v[d] = (flip_at >= 0) && (int'(heads.size()) == flip_at);
      if (busy_w[d]) busy_cnt++;
      if (done_w[d]) begin
        done_k = k;
        break;
      end
      if (abort_at >= 0) begin
        if (k == abort_at) abort_v[d] = 1'b1;
        if (k == abort_at + 1) break;
      end
    end
    start_v[d] = 1'b0;
    flip_v[d]  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if ({addr_w[d], head_w[d], pclk_w[d], busy_w[d], done_w[d], err_w[d]} !== 13'd0)
        $display("FAIL reset_outputs dut%0d: got %b, need all zero", d,
                 {addr_w[d], head_w[d], pclk_w[d], busy_w[d], done_w[d], err_w[d]});
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy_w, done_w} !== 6'd0) $display("FAIL reset_idle_wait: busy/done %b, need 000000", {busy_w, done_w});
    else n_pass++;
  endtask

  task automatic test_basic_load();
    int mism;
    mem_a[0] = 1; mem_a[1] = 0; mem_a[2] = 1; mem_a[3] = 1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mem_a[i]);
    run_load(0, 1, 100, -1, -1, 1'b0);
    mism = 0;
    for (int i = 0; i < heads.size(); i++) if (i >= exp_q.size() || heads[i] !== exp_q[i]) mism++;
    n_total++;
    if (heads.size() != exp_q.size() || mism != 0)
      $display("FAIL basic_heads: got %0d bits (%0d wrong), need %0d", heads.size(), mism, exp_q.size());
    else n_pass++;
    n_total++;
    if (done_k !== 4 * 3) $display("FAIL basic_done_time: got %0d, need %0d", done_k, 4 * 3);
    else n_pass++;
    n_total++;
    if (addr_w[0] !== 8'd3) $display("FAIL basic_final_addr: got %0d, need 3", addr_w[0]);
    else n_pass++;
    n_total++;
    if ({busy_w[0], err_w[0], addr0} !== {1'b0, 1'b0, 8'd0})
      $display("FAIL basic_status: busy %b error %b addr0 %0d, need 0 0 0", busy_w[0], err_w[0], addr0);
    else n_pass++;
  endtask

  task automatic test_abort();
    mem_a[0] = 1; mem_a[1] = 0; mem_a[2] = 1; mem_a[3] = 0;
    // bit 2 of pass 0: k=6 FETCH, k=7 LOW; abort raised in LOW
    run_load(0, 1, 100, 7, -1, 1'b0);
    n_total++;
    if ({pclk_w[0], busy_w[0], done_w[0]} !== 3'b000)
      $display("FAIL abort_idle: prog_clk/busy/done %b, need 000", {pclk_w[0], busy_w[0], done_w[0]});
    else n_pass++;
    n_total++;
    if (head_w[0] !== mem_a[2]) $display("FAIL abort_head_hold: got %b, need %b", head_w[0], mem_a[2]);
    else n_pass++;
    n_total++;
    if (heads.size() != 2) $display("FAIL abort_bits_shifted: got %0d, need 2", heads.size());
    else n_pass++;
    abort_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    abort_v[0] = 1'b0;
    n_total++;
    if ({busy_w[0], done_w[0], pclk_w[0]} !== 3'b000)
      $display("FAIL abort_in_idle: busy/done/prog_clk %b, need 000", {busy_w[0], done_w[0], pclk_w[0]});
    else n_pass++;
    mem_a[3] = 1;
    run_load(0, 1, 100, -1, -1, 1'b0);
    n_total++;
    if ({addr0, done_k} !== {8'd0, 32'd12})
      $display("FAIL abort_reload: addr0 %0d done at %0d, need 0 and 12", addr0, done_k);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int k;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    n_total++;
    if (pclk_w[0] !== 1'b1) $display("FAIL midload_in_high: prog_clk %b, need 1", pclk_w[0]);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({addr_w[0], head_w[0], pclk_w[0], busy_w[0], done_w[0], err_w[0]} !== 13'd0)
      $display("FAIL midload_async_reset: got %b, need all zero",
               {addr_w[0], head_w[0], pclk_w[0], busy_w[0], done_w[0], err_w[0]});
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy_w[0], addr_w[0], pclk_w[0]} !== {1'b1, 8'd0, 1'b0})
      $display("FAIL midload_restart: busy %b addr %0d prog_clk %b, need 1 0 0", busy_w[0], addr_w[0], pclk_w[0]);
    else n_pass++;
    start_v[0] = 1'b0;
    k = 0;
    while (!done_w[0] && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (k !== 12) $display("FAIL midload_done_time: got %0d, need 12", k);
    else n_pass++;
  endtask

  task automatic test_verify_pass();
    int mism;
    mem_b[0] = 1; mem_b[1] = 0; mem_b[2] = 1; mem_b[3] = 1;
    tail_zero_b = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 2; p++) for (int i = 0; i < 4; i++) exp_q.push_back(mem_b[i]);
    run_load(1, 1, 200, -1, -1, 1'b0);
    n_total++;
    if ({done_k, busy_cnt} !== {32'd24, 32'd24})
      $display("FAIL verify_time: done at %0d busy for %0d, need 24 and 24", done_k, busy_cnt);
    else n_pass++;
    n_total++;
    if (err_w[1] !== 1'b0) $display("FAIL verify_error_clear: got %b, need 0", err_w[1]);
    else n_pass++;
    n_total++;
    if (sr_b !== {mem_b[0], mem_b[1], mem_b[2], mem_b[3]})
      $display("FAIL verify_chain_content: got %b, need %b", sr_b, {mem_b[0], mem_b[1], mem_b[2], mem_b[3]});
    else n_pass++;
    mism = 0;
    for (int i = 0; i < heads.size(); i++) if (i >= exp_q.size() || heads[i] !== exp_q[i]) mism++;
    n_total++;
    if (heads.size() != exp_q.size() || mism != 0)
      $display("FAIL verify_heads: got %0d bits (%0d wrong), need %0d", heads.size(), mism, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_verify_fail();
    logic exp_err;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) if (mem_b[i]) exp_err = 1'b1;
    tail_zero_b = 1'b1;
    run_load(1, 1, 200, -1, -1, 1'b0);
    tail_zero_b = 1'b0;
    n_total++;
    if ({done_k, err_w[1]} !== {32'd24, exp_err})
      $display("FAIL verify_fail_flag: done at %0d error %b, need 24 and %b", done_k, err_w[1], exp_err);
    else n_pass++;
    abort_v[1] = 1'b1;
    repeat (5) @(negedge clk);
    abort_v[1] = 1'b0;
    n_total++;
    if ({done_w[1], err_w[1], busy_w[1]} !== {1'b1, exp_err, 1'b0})
      $display("FAIL verify_fail_hold: done/error/busy %b, need 1%b0", {done_w[1], err_w[1], busy_w[1]}, exp_err);
    else n_pass++;
    run_load(1, 1, 200, -1, -1, 1'b0);
    n_total++;
    if ({err0, err_w[1], done_k} !== {1'b0, 1'b0, 32'd24})
      $display("FAIL verify_restart_clears: error at start %b at end %b done %0d, need 0 0 24", err0, err_w[1], done_k);
    else n_pass++;
  endtask

  task automatic test_clk_div3();
    int mism;
    mem_c[0] = 1; mem_c[1] = 1; mem_c[2] = 0; mem_c[3] = 1; mem_c[4] = 0;
    exp_q.delete();
    for (int p = 0; p < 2; p++) for (int i = 0; i < 5; i++) exp_q.push_back(mem_c[i]);
    // start stays high during the whole load and must be ignored
    run_load(2, 3, 400, -1, -1, 1'b1);
    n_total++;
    if ({done_k, busy_cnt} !== {32'd70, 32'd70})
      $display("FAIL div3_time: done at %0d busy for %0d, need 70 and 70", done_k, busy_cnt);
    else n_pass++;
    n_total++;
    if ({hi_bad, lo_bad, hi_runs} !== {32'd0, 32'd0, 32'd10})
      $display("FAIL div3_prog_clk_shape: bad high %0d bad low %0d high pulses %0d, need 0 0 10", hi_bad, lo_bad, hi_runs);
    else n_pass++;
    mism = 0;
    for (int i = 0; i < heads.size(); i++) if (i >= exp_q.size() || heads[i] !== exp_q[i]) mism++;
    n_total++;
    if (heads.size() != exp_q.size() || mism != 0)
      $display("FAIL div3_heads: got %0d bits (%0d wrong), need %0d", heads.size(), mism, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int         flip_at, mism;
    logic       exp_err;
    logic [4:0] exp_sr;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 5; i++) mem_c[i] = 1'($urandom_range(0, 1));
      if (it == 0) flip_at = 7;
      else if (it == 1) flip_at = 2;
      else flip_at = int'($urandom_range(0, 10)) - 1;
      exp_err = (flip_at >= 5);
      exp_q.delete();
      for (int p = 0; p < 2; p++) for (int i = 0; i < 5; i++) exp_q.push_back(mem_c[i]);
      for (int i = 0; i < 5; i++) exp_sr[4 - i] = mem_c[i];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_load(2, 3, 400, -1, flip_at, 1'b0);
      mism = 0;
      for (int i = 0; i < heads.size(); i++) if (i >= exp_q.size() || heads[i] !== exp_q[i]) mism++;
      n_total++;
      if (heads.size() != exp_q.size() || mism != 0)
        $display("FAIL random_heads it%0d: got %0d bits (%0d wrong), need %0d", it, heads.size(), mism, exp_q.size());
      else n_pass++;
      n_total++;
      if ({done_k, err_w[2]} !== {32'd70, exp_err})
        $display("FAIL random_result it%0d flip %0d: done at %0d error %b, need 70 and %b", it, flip_at, done_k, err_w[2], exp_err);
      else n_pass++;
      n_total++;
      if (sr_c !== exp_sr) $display("FAIL random_chain it%0d: got %b, need %b", it, sr_c, exp_sr);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_abort();
    test_reset_mid_load();
    test_verify_pass();
    test_verify_fail();
    test_clk_div3();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/config_chain_controller.md
CONFIG_CHAIN_CONTROLLER -- requirements
Module: config_chain_controller

Interface
REQ-001 Parameter BITSTREAM_SIZE, default 6140, number of bits in one chain load (legal range 2..16384).
REQ-002 Parameter ADDR_WIDTH, default 14, width of mem_addr.
REQ-003 Parameter CLK_DIV, default 2, prog_clk half-period in clk cycles (legal range 1..255).
REQ-004 Parameter VERIFY, default 1, 1 enables the readback pass, 0 disables it.
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  level request to begin a load; sampled in IDLE and DONE.
REQ-008 abort  input  1  synchronous abort of a load in progress.
REQ-009 bit_in  input  1  bitstream memory read data; valid one clk after mem_addr changes (synchronous read).
REQ-010 chain_tail  input  1  serial output of the configuration chain, used for readback.
REQ-011 mem_addr  output  ADDR_WIDTH  registered bitstream memory read address.
REQ-012 chain_head  output  1  registered serial data driven into the chain.
REQ-013 prog_clk  output  1  registered chain shift clock; the chain shifts on its rising edge.
REQ-014 busy  output  1  high from leaving IDLE/DONE until DONE or abort.
REQ-015 done  output  1  level, high in DONE.
REQ-016 error  output  1  sticky readback mismatch flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, FETCH, LOW, HIGH and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL on the next edge do all of the following: set mem_addr=0, bit_cnt=0, pass=0, busy=1, done=0 and error=0, then enter FETCH.
REQ-019 FETCH SHALL last exactly 1 clk with prog_clk=0, then enter LOW.
REQ-020 On entry to LOW, chain_head SHALL load bit_in.
REQ-021 chain_head SHALL hold its value through LOW and HIGH.
REQ-022 LOW SHALL last CLK_DIV clks with prog_clk=0, then enter HIGH.
REQ-023 HIGH SHALL last CLK_DIV clks with prog_clk=1.
REQ-024 Each bit SHALL take exactly 1+2*CLK_DIV clks.
REQ-025 A pass SHALL take exactly BITSTREAM_SIZE*(1+2*CLK_DIV) clks.
REQ-026 At the end of HIGH with bit_cnt<BITSTREAM_SIZE-1, the block SHALL set bit_cnt+=1 and mem_addr+=1, then enter FETCH.
REQ-027 At the end of HIGH with bit_cnt==BITSTREAM_SIZE-1, VERIFY=1 and pass=0, the block SHALL set pass=1, bit_cnt=0 and mem_addr=0, then enter FETCH (second pass, same bitstream).
REQ-028 At the end of HIGH with bit_cnt==BITSTREAM_SIZE-1 in any other case, the block SHALL enter DONE with busy=0, done=1 and prog_clk=0.
REQ-029 When pass=1, on the last clk of LOW the block SHALL compare chain_tail with chain_head and set error=1 on mismatch.
REQ-030 error SHALL stay high until the next start or rst.
REQ-031 The block SHALL never update error when pass=0.
REQ-032 After a verify pass the chain content SHALL equal the bitstream, because the second pass reshifts identical data.
REQ-033 bit_cnt SHALL be wide enough for BITSTREAM_SIZE-1.
REQ-034 mem_addr SHALL never exceed BITSTREAM_SIZE-1 and SHALL never wrap during a pass.
REQ-035 abort=1 in FETCH/LOW/HIGH SHALL on the next edge enter IDLE with prog_clk=0, busy=0 and done=0.
REQ-036 On abort, error and chain_head SHALL hold their values.
REQ-037 abort SHALL take priority over every other transition.
REQ-038 In IDLE or DONE, abort SHALL have no effect, and start SHALL be ignored while busy=1.
REQ-039 In DONE, start=1 SHALL restart the load per REQ-018.
REQ-040 While in DONE with start low, done SHALL stay 1.
REQ-041 prog_clk SHALL be glitch-free, directly from a flop.

Reset
REQ-042 rst=1 SHALL immediately force state=IDLE.
REQ-043 rst=1 SHALL immediately force mem_addr=0, bit_cnt=0, pass=0, chain_head=0, prog_clk=0, busy=0, done=0 and error=0.
REQ-044 rst asserted mid-load SHALL discard the load.
REQ-045 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-046 Basic load (BITSTREAM_SIZE=4, CLK_DIV=1, VERIFY=0, memory 1,0,1,1, start pulse) -> required response:
- chain_head is 1,0,1,1 across 4 prog_clk rising edges;
- done=1 exactly 12 clks after the FETCH entry;
- mem_addr ends at 3.
REQ-047 Verify pass with a 4-bit shift-register model as chain and VERIFY=1 -> 24 clks busy, then done=1 with error=0, and the model holds 1,0,1,1.
REQ-048 Verify fail: the model's chain_tail output is forced to 0 -> done=1 and error=1 after 24 clks.
REQ-049 Abort at bit 2 of pass 0 -> required response:
- next clk is IDLE with prog_clk=0, busy=0 and done=0;
- a subsequent start reloads from mem_addr=0.
REQ-050 Asynchronous rst asserted during HIGH -> all outputs are 0 without waiting for a clk edge, and with start held high the load restarts from addr 0 after rst release.
REQ-051 CLK_DIV=3 -> prog_clk high for 3 clks and low for 4 clks per bit (FETCH+LOW), and start asserted while busy=1 is ignored.
